mem_arbiter: RTL and testbench

//  Shares the single data-memory port between instruction fetch (read-only) and the execute

---
 rtl/bf8b_pkg.sv | 16 +
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf8b_pkg.sv
// rtl/bf8b_pkg.sv - shared types and constants for the fetch/exec memory arbiter
package bf8b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_EXEC  = 1'b1;

    localparam int READ_LAT_DEF = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick between fetch and exec requests
module rr_arb2
    import bf8b_pkg::*;
(
    input  logic f_req,
    input  logic x_req,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    // On a tie the side that did not win last time goes next.
    always_comb begin
        valid = f_req | x_req;
        if (f_req && x_req) begin
            grant = ~last_grant;
        end else if (x_req) begin
            grant = OWN_EXEC;
        end else begin
            grant = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch (read) and exec (read/write)
// and sequences each access through issue, fixed read latency and a one-cycle done pulse.
module mem_arbiter
    import bf8b_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_done,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic [DATA_W-1:0] x_rdata,
    output logic              x_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_in
);

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       we_q;
    logic       last_grant;
    logic [2:0] lat_cnt;
    logic       grant;
    logic       grant_valid;
    logic       lat_hit;

    rr_arb2 u_rr_arb2 (
        .f_req      (f_req),
        .x_req      (x_req),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (grant_valid)
    );

    assign lat_hit = (lat_cnt == 3'(READ_LAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        f_done     = 1'b0;
        x_done     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                f_done     = (owner == OWN_FETCH);
                x_done     = (owner == OWN_EXEC);
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched only in IDLE so the requester may change them mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= OWN_FETCH;
            we_q         <= 1'b0;
            last_grant   <= OWN_FETCH;
            lat_cnt      <= 3'd0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_we       <= 1'b0;
            f_rdata      <= '0;
            x_rdata      <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (grant == OWN_EXEC) begin
                            we_q         <= x_we;
                            mem_addr     <= x_addr;
                            mem_data_out <= x_wdata;
                            mem_we       <= x_we;
                        end else begin
                            we_q     <= 1'b0;
                            mem_addr <= f_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (!we_q) begin
                        lat_cnt <= 3'd1;
                    end
                end
                WAIT: begin
                    if (lat_hit) begin
                        if (owner == OWN_EXEC) begin
                            x_rdata <= mem_data_in;
                        end else begin
                            f_rdata <= mem_data_in;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter at read latencies 2, 1 and 7
module tb_mem_arbiter;

    localparam int NDEV = 3;

    typedef struct {
        int         d;
        bit         ex;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
    } vec_t;

    logic       clk;
    logic       rst          [NDEV];
    logic       f_req        [NDEV];
    logic [7:0] f_addr       [NDEV];
    logic [7:0] f_rdata      [NDEV];
    logic       f_done       [NDEV];
    logic       x_req        [NDEV];
    logic       x_we         [NDEV];
    logic [7:0] x_addr       [NDEV];
    logic [7:0] x_wdata      [NDEV];
    logic [7:0] x_rdata      [NDEV];
    logic       x_done       [NDEV];
    logic [7:0] mem_addr     [NDEV];
    logic [7:0] mem_data_out [NDEV];
    logic       mem_we       [NDEV];
    logic [7:0] mem_data_in  [NDEV];

    logic [7:0] mem [256];
    logic       mem_clr;

    int n_chk;
    int n_fail;
    int cur_d;
    int cur_t;

    for (genvar g = 0; g < NDEV; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W   (8),
            .DATA_W   (8),
            .READ_LAT ((g == 0) ? 2 : ((g == 1) ? 1 : 7))
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .f_req        (f_req[g]),
            .f_addr       (f_addr[g]),
            .f_rdata      (f_rdata[g]),
            .f_done       (f_done[g]),
            .x_req        (x_req[g]),
            .x_we         (x_we[g]),
            .x_addr       (x_addr[g]),
            .x_wdata      (x_wdata[g]),
            .x_rdata      (x_rdata[g]),
            .x_done       (x_done[g]),
            .mem_addr     (mem_addr[g]),
            .mem_data_out (mem_data_out[g]),
            .mem_we       (mem_we[g]),
            .mem_data_in  (mem_data_in[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input int a);
        case (a)
            8'h10:   return 8'hA7;
            8'hFF:   return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        end else begin
            for (int k = 0; k < NDEV; k++) begin
                if (mem_we[k]) mem[mem_addr[k]] <= mem_data_out[k];
            end
        end
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dev%0d t%0d: got %0h, expected %0h", name, cur_d, cur_t, act, exp);
        end
    endtask

    task automatic chk_zero(input int d);
        chk("rst_f_done", 32'(f_done[d]), 0);
        chk("rst_x_done", 32'(x_done[d]), 0);
        chk("rst_mem_we", 32'(mem_we[d]), 0);
        chk("rst_mem_addr", 32'(mem_addr[d]), 0);
        chk("rst_mem_data_out", 32'(mem_data_out[d]), 0);
        chk("rst_f_rdata", 32'(f_rdata[d]), 0);
        chk("rst_x_rdata", 32'(x_rdata[d]), 0);
    endtask

    // Called at posedge+1 of an IDLE cycle; this cycle is t=0 of the access.
    task automatic access(input int d, input bit ex, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd, input bit drop);
        int         lat;
        int         tdone;
        logic [7:0] other_rd;
        lat   = lat_of(d);
        tdone = we ? 2 : 2 + lat;
        cur_d = d;
        other_rd = ex ? f_rdata[d] : x_rdata[d];
        if (ex) begin
            x_req[d] = 1'b1; x_we[d] = we; x_addr[d] = addr; x_wdata[d] = wdata;
        end else begin
            f_req[d] = 1'b1; f_addr[d] = addr;
        end
        for (int t = 0; t <= tdone; t++) begin
            cur_t = t;
            mem_data_in[d] = (!we && t == 1 + lat) ? mem[mem_addr[d]] : 8'hEE;
            chk(ex ? "x_done" : "f_done", 32'(ex ? x_done[d] : f_done[d]), 32'(t == tdone));
            chk(ex ? "f_done_idle" : "x_done_idle", 32'(ex ? f_done[d] : x_done[d]), 0);
            chk("mem_we", 32'(mem_we[d]), 32'(t == 1 && we));
            if (t >= 1) chk("mem_addr", 32'(mem_addr[d]), 32'(addr));
            if (t == 1 && we) chk("mem_data_out", 32'(mem_data_out[d]), 32'(wdata));
            if (t == tdone) begin
                if (!we) chk(ex ? "x_rdata" : "f_rdata", 32'(ex ? x_rdata[d] : f_rdata[d]), 32'(exp_rd));
                chk(ex ? "f_rdata_kept" : "x_rdata_kept", 32'(ex ? f_rdata[d] : x_rdata[d]), 32'(other_rd));
                if (drop) begin
                    if (ex) x_req[d] = 1'b0; else f_req[d] = 1'b0;
                end
            end
            if (t == 2) begin
                if (ex) begin
                    x_addr[d] = addr ^ 8'hFF; x_we[d] = ~we; x_wdata[d] = ~wdata;
                end else begin
                    f_addr[d] = addr ^ 8'hFF;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{0, 1'b1, 1'b1, 8'hE3, 8'h5A, 8'h00};
        vecs[1]  = '{0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA7};
        vecs[2]  = '{0, 1'b1, 1'b0, 8'hE3, 8'h00, 8'h5A};
        vecs[3]  = '{0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[4]  = '{0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[5]  = '{0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA7};
        vecs[6]  = '{0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C};
        vecs[7]  = '{1, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA7};
        vecs[8]  = '{1, 1'b1, 1'b1, 8'h44, 8'hC1, 8'h00};
        vecs[9]  = '{1, 1'b1, 1'b0, 8'h44, 8'h00, 8'hC1};
        vecs[10] = '{2, 1'b0, 1'b0, 8'h44, 8'h00, 8'hC1};
        vecs[11] = '{2, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C};

        n_chk = 0; n_fail = 0; cur_d = 0; cur_t = 0;
        mem_clr = 1'b1;
        for (int d = 0; d < NDEV; d++) begin
            rst[d] = 1'b1; f_req[d] = 1'b0; f_addr[d] = 8'h00; x_req[d] = 1'b0;
            x_we[d] = 1'b0; x_addr[d] = 8'h00; x_wdata[d] = 8'h00; mem_data_in[d] = 8'h00;
        end
        f_req[0] = 1'b1;
        x_req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        for (int d = 0; d < NDEV; d++) begin
            cur_d = d;
            chk_zero(d);
        end
        for (int d = 0; d < NDEV; d++) rst[d] = 1'b0;

        // Both requesting from reset: exec, fetch, exec.
        access(0, 1'b1, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0);
        access(0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h11, 1'b1);
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA7, 1'b1);

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].d, vecs[i].ex, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd, 1'b1);
        end

        // Exec back-to-back, request held through each done.
        access(0, 1'b1, 1'b1, 8'h30, 8'h77, 8'h00, 1'b0);
        access(0, 1'b1, 1'b0, 8'h30, 8'h00, 8'h77, 1'b0);
        access(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA7, 1'b1);

        // Reset during WAIT of a fetch read.
        cur_d = 0; cur_t = 100;
        f_addr[0] = 8'h10; f_req[0] = 1'b1; mem_data_in[0] = 8'hEE;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst[0] = 1'b1;
        #1;
        chk_zero(0);
        f_req[0] = 1'b0;
        @(posedge clk);
        #1;
        chk_zero(0);
        rst[0] = 1'b0;
        access(0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA7, 1'b1);

        // Reset while a write is being issued.
        cur_d = 0; cur_t = 200;
        x_req[0] = 1'b1; x_we[0] = 1'b1; x_addr[0] = 8'h55; x_wdata[0] = 8'h99;
        @(posedge clk);
        #1;
        chk("issue_mem_we", 32'(mem_we[0]), 1);
        rst[0] = 1'b1;
        #1;
        chk("rst_mem_we_now", 32'(mem_we[0]), 0);
        x_req[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_x_done_after", 32'(x_done[0]), 0);
        chk("abandoned_write", 32'(mem[8'h55]), 0);
        rst[0] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
